// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the SRAM arbiter
package sram_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 6;
  localparam int DW_DEF   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // last_owner starts at the highest index so requester 0 wins the first search
  function automatic int last_owner_rst(input int nreq);
    return nreq - 1;
  endfunction

endpackage

// File: rtl/sram_arbiter_rr_picker.sv
// rtl/sram_arbiter_rr_picker.sv - rotating priority encoder starting after last owner
module rr_picker #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] eligible_i,
  input  logic [IW-1:0]   last_owner_i,
  output logic            valid_o,
  output logic [IW-1:0]   grant_o
);

  // Walk candidates from farthest to nearest so the nearest eligible one after last_owner wins
  always_comb begin
    valid_o = 1'b0;
    grant_o = '0;
    for (int k = NREQ; k >= 1; k--) begin
      logic [IW-1:0] cand;
      cand = IW'((int'(last_owner_i) + k) % NREQ);
      if (eligible_i[cand]) begin
        valid_o = 1'b1;
        grant_o = cand;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin arbiter sharing one SRAM macro between requesters
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  parameter  int AW   = AW_DEF,
  parameter  int DW   = DW_DEF,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic               wb_clk_i,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      rdata,
  output logic               busy,
  input  logic               fixed_en,
  input  logic [IW-1:0]      fixed_sel,
  output logic [AW-1:0]      sram_addr,
  output logic [DW-1:0]      sram_in,
  input  logic [DW-1:0]      sram_out,
  output logic               sram_gwe
);

  state_e          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_owner_q, last_owner_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   din_q, din_d;
  logic            gwe_q, gwe_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic [NREQ-1:0] lock_mask;
  logic [NREQ-1:0] eligible;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_wdata;

  // A requester being acked this cycle is masked so its still-high req is not re-granted
  assign lock_mask = {{(NREQ-1){1'b0}}, 1'b1} << fixed_sel;
  assign eligible  = fixed_en ? (req & ~ack_q & lock_mask) : (req & ~ack_q);
  assign win_addr  = addr[int'(pick_idx)*AW +: AW];
  assign win_wdata = wdata[int'(pick_idx)*DW +: DW];

  rr_picker #(.NREQ(NREQ)) u_picker (
    .eligible_i   (eligible),
    .last_owner_i (last_owner_q),
    .valid_o      (pick_valid),
    .grant_o      (pick_idx)
  );

  // Next-state, operand capture and ack/rdata generation
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    din_d        = din_q;
    gwe_d        = 1'b0;
    ack_d        = '0;
    rdata_d      = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d      = ST_ACC;
          owner_d      = pick_idx;
          last_owner_d = pick_idx;
          addr_d       = win_addr;
          din_d        = win_wdata;
          gwe_d        = we[pick_idx];
        end
      end
      ST_ACC: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d        = ST_IDLE;
        rdata_d        = sram_out;
        ack_d[owner_q] = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the write enable without waiting for a clock
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= IW'(last_owner_rst(NREQ));
      addr_q       <= '0;
      din_q        <= '0;
      gwe_q        <= 1'b0;
      ack_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      gwe_q        <= gwe_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign sram_addr = addr_q;
  assign sram_in   = din_q;
  assign sram_gwe  = gwe_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter
module tb_sram_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 6;
  localparam int DW   = 8;

  logic               wb_clk_i = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      rdata;
  logic               busy;
  logic               fixed_en;
  logic [1:0]         fixed_sel;
  logic [AW-1:0]      sram_addr;
  logic [DW-1:0]      sram_in;
  logic [DW-1:0]      sram_out;
  logic               sram_gwe;

  always #5 wb_clk_i = ~wb_clk_i;

  sram_arbiter dut (
    .wb_clk_i  (wb_clk_i),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .ack       (ack),
    .rdata     (rdata),
    .busy      (busy),
    .fixed_en  (fixed_en),
    .fixed_sel (fixed_sel),
    .sram_addr (sram_addr),
    .sram_in   (sram_in),
    .sram_out  (sram_out),
    .sram_gwe  (sram_gwe)
  );

  // Behavioural 64x8 macro with a preload port
  logic [DW-1:0] smem [64];
  logic          pl_en;
  logic [AW-1:0] pl_a;
  logic [DW-1:0] pl_d;
  always @(posedge wb_clk_i) begin
    if (pl_en) begin
      smem[pl_a] <= pl_d;
    end else begin
      if (sram_gwe) smem[sram_addr] <= sram_in;
      sram_out <= smem[sram_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  // Transaction-level reference model
  int            cyc;
  bit            pend_v;
  int            pend_owner;
  int            pend_acc;
  bit            pend_wr;
  logic [DW-1:0] pend_rd;
  int            last;
  logic [AW-1:0] hold_a;
  logic [DW-1:0] hold_d;
  logic [DW-1:0] rmem [64];
  int            ack_log[$];
  logic [3:0]    last_ack;
  bit            rereq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend_v = 1'b0;
    last   = NREQ - 1;
    hold_a = '0;
    hold_d = '0;
  endtask

  task automatic issue(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]            = 1'b1;
    we[i]             = w;
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic issue_rand(input int i);
    issue(i, bit'($urandom_range(1)), AW'($urandom), DW'($urandom));
  endtask

  task automatic grant(input int i);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a          = addr[i*AW +: AW];
    d          = wdata[i*DW +: DW];
    pend_v     = 1'b1;
    pend_owner = i;
    pend_acc   = cyc + 1;
    pend_wr    = we[i];
    hold_a     = a;
    hold_d     = d;
    last       = i;
    if (we[i]) rmem[a] = d;
    else       pend_rd = rmem[a];
  endtask

  task automatic check_and_step();
    logic [3:0] exp_ack;
    logic [3:0] elig;
    bit         idle;
    @(negedge wb_clk_i);
    if (!rst_n) begin
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_gwe", sram_gwe, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_addr", sram_addr, 0);
      chk("rst_din", sram_in, 0);
      last_ack = '0;
      return;
    end
    exp_ack = (pend_v && cyc == pend_acc + 2) ? 4'(1 << pend_owner) : 4'd0;
    chk("ack", ack, exp_ack);
    if (exp_ack != 0 && !pend_wr) chk("rdata", rdata, pend_rd);
    chk("gwe", sram_gwe, pend_v && cyc == pend_acc && pend_wr);
    chk("busy", busy, pend_v && (cyc == pend_acc || cyc == pend_acc + 1));
    chk("sram_addr", sram_addr, hold_a);
    chk("sram_in", sram_in, hold_d);
    for (int i = 0; i < NREQ; i++) if (ack[i] === 1'b1) ack_log.push_back(i);
    last_ack = ack;
    idle = !pend_v || cyc == pend_acc + 2;
    if (idle) begin
      pend_v = 1'b0;
      elig   = req & ~exp_ack;
      if (fixed_en) elig = elig & 4'(1 << fixed_sel);
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (last + k) % NREQ;
        if (elig[c]) begin
          grant(c);
          break;
        end
      end
    end
  endtask

  task automatic tick();
    check_and_step();
    @(posedge wb_clk_i);
    #1;
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      if (last_ack[i] === 1'b1) begin
        if (rereq) issue_rand(i);
        else       req[i] = 1'b0;
      end
    end
  endtask

  task automatic wait_acc(input string tag);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 16; n++) begin
      if (pend_v && pend_acc == cyc) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, found, 1);
  endtask

  task automatic chk_log(input string tag, input int j, input int exp);
    int v;
    v = (j < ack_log.size()) ? ack_log[j] : -1;
    chk(tag, v, exp);
  endtask

  initial begin
    int rr_exp[5];
    rr_exp = '{0, 1, 2, 3, 0};
    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    fixed_en = 1'b0; fixed_sel = 2'd0; rereq = 1'b0; last_ack = '0;
    pl_en = 1'b1; pl_a = '0; pl_d = '0;
    for (int a = 0; a < 64; a++) begin
      pl_a = AW'(a);
      pl_d = (a == 42) ? 8'h5C : DW'($urandom);
      rmem[a] = pl_d;
      @(posedge wb_clk_i);
      #1;
    end
    pl_en = 1'b0;
    model_reset();
    cyc = 0;
    tick();
    tick();
    rst_n = 1'b1;

    // Single read of a preloaded location by requester 2
    ack_log.delete();
    issue(2, 1'b0, 6'h2A, 8'h11);
    repeat (6) tick();
    chk("single_rd_count", ack_log.size(), 1);
    chk_log("single_rd_who", 0, 2);
    chk("single_rd_data", rdata, 8'h5C);

    // Write then read back by requester 0
    issue(0, 1'b1, 6'h3F, 8'hA7);
    repeat (5) tick();
    issue(0, 1'b0, 6'h3F, 8'h00);
    repeat (5) tick();
    chk("wr_rd_data", rdata, 8'hA7);

    // All four requesting from reset
    rst_n = 1'b0;
    model_reset();
    rereq = 1'b1;
    for (int i = 0; i < NREQ; i++) issue_rand(i);
    tick();
    rst_n = 1'b1;
    ack_log.delete();
    repeat (16) tick();
    for (int j = 0; j < 5; j++) chk_log("rr_order", j, rr_exp[j]);

    // Lock to requester 1
    fixed_en = 1'b1;
    fixed_sel = 2'd1;
    repeat (4) tick();
    ack_log.delete();
    repeat (9) tick();
    chk("lock_count", ack_log.size() >= 2, 1);
    for (int j = 0; j < ack_log.size(); j++) chk_log("lock_only1", j, 1);
    wait_acc("lock_acc_found");
    fixed_en = 1'b0;
    ack_log.delete();
    repeat (8) tick();
    chk_log("unlock_first", 0, 1);
    chk_log("unlock_next", 1, 2);

    // Requester 3 drops req during its access
    rereq = 1'b0;
    req = '0;
    repeat (6) tick();
    issue(3, 1'b0, AW'($urandom), DW'($urandom));
    wait_acc("drop_acc_found");
    req[3] = 1'b0;
    ack_log.delete();
    repeat (6) tick();
    chk("drop_count", ack_log.size(), 1);
    chk_log("drop_who", 0, 3);

    // Reset in the middle of a write; the data equals the current content so either outcome is consistent
    issue(0, 1'b1, 6'h15, rmem[21]);
    wait_acc("mw_acc_found");
    chk("mw_gwe_pre", sram_gwe, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mw_gwe_async", sram_gwe, 0);
    chk("mw_busy", busy, 0);
    chk("mw_ack", ack, 0);
    chk("mw_addr", sram_addr, 0);
    model_reset();
    req = '0;
    tick();
    issue(1, 1'b0, AW'($urandom), DW'($urandom));
    issue(0, 1'b0, AW'($urandom), DW'($urandom));
    rst_n = 1'b1;
    ack_log.delete();
    repeat (8) tick();
    chk_log("mw_first", 0, 0);
    chk_log("mw_second", 1, 1);

    // Randomized traffic against the model
    repeat (600) begin
      tick();
      for (int i = 0; i < NREQ; i++) if (!req[i] && $urandom_range(3) == 0) issue_rand(i);
      if ($urandom_range(40) == 0) begin
        fixed_en  = ~fixed_en;
        fixed_sel = 2'($urandom);
      end
    end
    fixed_en = 1'b0;
    req = '0;
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single 64×8 on-chip SRAM macro between up to four project wrappers (QCPU and sibling designs) in the multi-project user area. Grants one access at a time under rotating round-robin priority, drives the macro's address, data and write-enable pins, and returns read data with a one-cycle acknowledge. Firmware can override arbitration from the custom settings register and lock the SRAM to one wrapper.

## Interface
Parameters:
- NREQ, 4: number of requesters; fixed_sel is $clog2(NREQ) bits wide.
- AW, 6: SRAM address width.
- DW, 8: SRAM data width.

Ports:
- wb_clk_i  in  1  the single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester access request, level; held until ack.
- we  in  NREQ  per-requester write strobe qualifier; 1 = write, 0 = read.
- addr  in  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW].
- wdata  in  NREQ*DW  packed write data; requester i uses bits [i*DW +: DW].
- ack  out  NREQ  one-hot, one-cycle completion pulse.
- rdata  out  DW  read data broadcast to all requesters; valid while ack is high.
- busy  out  1  high while an access is in flight (ACC or DONE).
- fixed_en  in  1  from custom_settings; 1 = lock mode.
- fixed_sel  in  2  from custom_settings; the locked requester index.
- sram_addr  out  AW  to macro.
- sram_in  out  DW  write data to macro.
- sram_out  in  DW  read data from macro, valid one cycle after address is sampled.
- sram_gwe  out  1  global write-enable to macro, active high.

## Operation
- FSM states: IDLE, ACC, DONE. Transitions: IDLE→ACC when an eligible request exists; ACC→DONE unconditionally; DONE→IDLE unconditionally.
- Eligibility:
  - Requester i is eligible when req[i]=1 and ack[i]=0 in that cycle. Masking a requester's ack cycle prevents a stale re-grant.
  - In lock mode (fixed_en=1), only requester fixed_sel is eligible.
- Round-robin:
  - Search starts at last_owner+1 (mod NREQ) and picks the first eligible index.
  - last_owner updates on every grant. It resets to NREQ-1, so requester 0 wins first.
- On the IDLE→ACC edge:
  - Register owner, addr, wdata and we of the winner.
  - sram_gwe is registered to the winner's we.
- ACC: sram_addr, sram_in and sram_gwe are driven from registers. The macro samples at the end of ACC. sram_gwe is high only in ACC.
- DONE:
  - sram_gwe=0.
  - On the DONE→IDLE edge, rdata is registered from sram_out.
  - On the same edge, ack[owner] is set for exactly one cycle.
  - For writes, rdata is still updated; its content is don't-care.
- Outside ACC, sram_addr and sram_in hold their last value.
- Reset values: ack=0, rdata=0, busy=0, sram_gwe=0, sram_addr=0, sram_in=0, state=IDLE, last_owner=NREQ-1.
- Changes to fixed_en or fixed_sel take effect at the next IDLE arbitration. An access already in flight always completes and is acknowledged.
- Reset asserted mid-access aborts immediately and sram_gwe drops asynchronously. A write interrupted this way may or may not land; no ack is issued.
- A requester that drops req before ack still completes its granted access and receives ack.

## Timing
- Latency: req rises in cycle 0 while the arbiter is IDLE → ACC in cycle 1, DONE in cycle 2, ack and rdata in cycle 3.
- The ack cycle coincides with IDLE, where the next grant is decided. The sustained rate is one access per 3 cycles.
- Worst-case wait with NREQ continuously requesting is 3·NREQ cycles. In lock mode, non-locked requesters wait indefinitely.

## Structure
- Package sram_arb_pkg holds:
  - the state enum (IDLE, ACC, DONE);
  - default AW, DW and NREQ constants;
  - the reset value of last_owner.
- One sub-module, rr_picker: combinational rotate plus priority encoder.
  - Inputs: eligible[NREQ], last_owner.
  - Outputs: valid and grant index.
- The top level holds the FSM, operand registers and ack/rdata registers.

## Test plan
- Single read: preload addr 0x2A=0x5C; requester 2 reads 0x2A → ack[2] three cycles after req, rdata=0x5C, sram_gwe never high.
- Write then read: requester 0 writes 0xA7 to 0x3F → sram_gwe high exactly one cycle (ACC) with sram_addr=0x3F and sram_in=0xA7; a subsequent read returns 0xA7.
- Round-robin: all four req held from reset → grant order 0,1,2,3,0; ack spacing exactly 3 cycles; no requester acked twice consecutively.
- Lock mode: fixed_en=1, fixed_sel=1, all req high → only ack[1] pulses. Clearing fixed_en during an access → that access completes, then rotation resumes from requester 2.
- Reset mid-write: assert rst_n=0 during ACC → sram_gwe=0 immediately; all outputs at reset values; no ack. After release, requester 0 is granted first.
- Early drop: requester 3 deasserts req during ACC → ack[3] still pulses in cycle 3; no re-grant to requester 3.
